// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and misalign check for the data-memory arbiter
package dmem_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   is_load;
    logic   err;
  } resp_t;

  // mode 2'b11 is also a word access, so only mode[1] is tested for word size
  function automatic logic misalign(input logic [1:0] mode, input logic [1:0] addr_lo);
    misalign = ((mode == MODE_HALF) && addr_lo[0]) ||
               (mode[1] && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DBG and RAM side signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_mode;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [1:0]        dbg_mode;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  logic              mem_we;
  logic [1:0]        mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    input  dbg_req, dbg_we, dbg_mode, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_we, mem_mode, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
    output dbg_req, dbg_we, dbg_mode, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_we, mem_mode, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_resp_reg.sv
// rtl/dmem_resp_reg.sv - registers the granted access and steers the late read data to its owner
module dmem_resp_reg
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  owner_e            gnt_owner,
  input  logic              gnt_load,
  input  logic              gnt_err,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err
);

  resp_t resp_q;
  resp_t resp_d;

  always_comb begin
    resp_d         = '0;
    resp_d.owner   = gnt_owner;
    resp_d.is_load = gnt_load;
    resp_d.err     = gnt_err;
  end

  // an asynchronous reset drops whatever response was in flight
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      resp_q <= '{owner: OWN_NONE, is_load: 1'b0, err: 1'b0};
    end else begin
      resp_q <= resp_d;
    end
  end

  always_comb begin
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    cpu_err    = 1'b0;
    dbg_rvalid = 1'b0;
    dbg_rdata  = '0;
    dbg_err    = 1'b0;
    case (resp_q.owner)
      OWN_CPU: begin
        cpu_err    = resp_q.err;
        cpu_rvalid = resp_q.is_load & ~resp_q.err;
        if (cpu_rvalid) cpu_rdata = mem_rdata;
      end
      // DBG acknowledges stores too, but only loads carry data
      OWN_DBG: begin
        dbg_err    = resp_q.err;
        dbg_rvalid = ~resp_q.err;
        if (resp_q.is_load && !resp_q.err) dbg_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DBG arbiter in front of the byte-lane data RAM with bounded DBG wait
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            CLK,
  input  logic            reset_n,
  dmem_arbiter_if.slave   bus
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  owner_e            owner;
  logic [3:0]        wait_cnt;
  logic              own_we;
  logic [1:0]        own_mode;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_mis;

  logic              cpu_rvalid_w;
  logic [DATA_W-1:0] cpu_rdata_w;
  logic              cpu_err_w;
  logic              dbg_rvalid_w;
  logic [DATA_W-1:0] dbg_rdata_w;
  logic              dbg_err_w;

  // CPU has priority until DBG has been denied MAX_WAIT cycles in a row
  always_comb begin
    owner = OWN_NONE;
    if (bus.dbg_req && ((wait_cnt == WAIT_MAX) || !bus.cpu_req)) begin
      owner = OWN_DBG;
    end else if (bus.cpu_req) begin
      owner = OWN_CPU;
    end
  end

  always_comb begin
    own_we    = 1'b0;
    own_mode  = bus.cpu_mode;
    own_addr  = bus.cpu_addr;
    own_wdata = bus.cpu_wdata;
    case (owner)
      OWN_CPU: own_we = bus.cpu_we;
      OWN_DBG: begin
        own_we    = bus.dbg_we;
        own_mode  = bus.dbg_mode;
        own_addr  = bus.dbg_addr;
        own_wdata = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  assign own_mis = misalign(own_mode, own_addr[1:0]);

  assign bus.cpu_stall = bus.cpu_req & (owner != OWN_CPU);
  assign bus.dbg_gnt   = (owner == OWN_DBG);

  // reset_n gates the write strobe so no store leaks out while reset is held
  assign bus.mem_we    = own_we & ~own_mis & reset_n;
  assign bus.mem_mode  = own_mode;
  assign bus.mem_addr  = own_addr;
  assign bus.mem_wdata = own_wdata;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (!bus.dbg_req || (owner == OWN_DBG)) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  dmem_resp_reg #(
    .DATA_W (DATA_W)
  ) u_resp (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .gnt_owner  (owner),
    .gnt_load   (~own_we),
    .gnt_err    (own_mis),
    .mem_rdata  (bus.mem_rdata),
    .cpu_rvalid (cpu_rvalid_w),
    .cpu_rdata  (cpu_rdata_w),
    .cpu_err    (cpu_err_w),
    .dbg_rvalid (dbg_rvalid_w),
    .dbg_rdata  (dbg_rdata_w),
    .dbg_err    (dbg_err_w)
  );

  assign bus.cpu_rvalid = cpu_rvalid_w;
  assign bus.cpu_rdata  = cpu_rdata_w;
  assign bus.cpu_err    = cpu_err_w;
  assign bus.dbg_rvalid = dbg_rvalid_w;
  assign bus.dbg_rdata  = dbg_rdata_w;
  assign bus.dbg_err    = dbg_err_w;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and random checks of dmem_arbiter against a byte-array reference
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int MAX_WAIT = 4;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAM: synchronous read, byte-lane little-endian writes, zero-extended narrow reads
  logic [7:0]  ram [256];
  logic [31:0] ram_q;
  logic        ram_clr = 1'b1;
  logic [7:0]  ra1, ra2, ra3;
  assign ra1 = bus.mem_addr + 8'd1;
  assign ra2 = bus.mem_addr + 8'd2;
  assign ra3 = bus.mem_addr + 8'd3;
  assign bus.mem_rdata = ram_q;

  always @(posedge CLK) begin
    case (bus.mem_mode)
      2'b00:   ram_q <= {24'h0, ram[bus.mem_addr]};
      2'b01:   ram_q <= {16'h0, ram[ra1], ram[bus.mem_addr]};
      default: ram_q <= {ram[ra3], ram[ra2], ram[ra1], ram[bus.mem_addr]};
    endcase
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata[7:0];
      if (bus.mem_mode != 2'b00) ram[ra1] <= bus.mem_wdata[15:8];
      if (bus.mem_mode[1]) begin
        ram[ra2] <= bus.mem_wdata[23:16];
        ram[ra3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // reference state
  logic [7:0]  mm [256];
  int          wcnt = 0;
  int          pend_own = 0;
  bit          pend_load = 1'b0;
  bit          pend_err = 1'b0;
  logic [31:0] pend_data = '0;
  bit          cpu_hold = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        s_stall, s_gnt, s_mem_we, s_cpu_rvalid, s_cpu_err, s_dbg_rvalid, s_dbg_err;
  logic [31:0] s_cpu_rdata, s_dbg_rdata;

  function automatic logic [31:0] mread(input int a, input int sz);
    logic [31:0] v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[(a + i) % 256];
    return v;
  endfunction

  task automatic mwrite(input int a, input int sz, input logic [31:0] d);
    for (int i = 0; i < sz; i++) mm[(a + i) % 256] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [1:0] mode,
                         input logic [7:0] addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_mode = mode;
    bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [1:0] mode,
                         input logic [7:0] addr, input logic [31:0] wd);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_mode = mode;
    bus.dbg_addr = addr; bus.dbg_wdata = wd;
  endtask

  // called at the falling edge: checks this cycle's outputs, then advances the reference
  task automatic eval();
    int          own, sz, a;
    bit          we, mis;
    logic [1:0]  md;
    logic [31:0] wd;
    s_stall = bus.cpu_stall; s_gnt = bus.dbg_gnt; s_mem_we = bus.mem_we;
    s_cpu_rvalid = bus.cpu_rvalid; s_cpu_rdata = bus.cpu_rdata; s_cpu_err = bus.cpu_err;
    s_dbg_rvalid = bus.dbg_rvalid; s_dbg_rdata = bus.dbg_rdata; s_dbg_err = bus.dbg_err;

    own = (bus.dbg_req && (wcnt == MAX_WAIT || !bus.cpu_req)) ? 2 : (bus.cpu_req ? 1 : 0);

    chk("cpu_rvalid", s_cpu_rvalid, 32'(pend_own == 1 && pend_load && !pend_err));
    chk("cpu_err",    s_cpu_err,    32'(pend_own == 1 && pend_err));
    chk("cpu_rdata",  s_cpu_rdata,  (pend_own == 1 && pend_load && !pend_err) ? pend_data : 32'h0);
    chk("dbg_rvalid", s_dbg_rvalid, 32'(pend_own == 2 && !pend_err));
    chk("dbg_err",    s_dbg_err,    32'(pend_own == 2 && pend_err));
    chk("dbg_rdata",  s_dbg_rdata,  (pend_own == 2 && pend_load && !pend_err) ? pend_data : 32'h0);
    chk("cpu_stall",  s_stall,      32'(bus.cpu_req && own != 1));
    chk("dbg_gnt",    s_gnt,        32'(own == 2));

    we = (own == 2) ? bus.dbg_we : ((own == 1) ? bus.cpu_we : 1'b0);
    md = (own == 2) ? bus.dbg_mode : bus.cpu_mode;
    a  = (own == 2) ? int'(bus.dbg_addr) : int'(bus.cpu_addr);
    wd = (own == 2) ? bus.dbg_wdata : bus.cpu_wdata;
    sz = (md == 2'b00) ? 1 : ((md == 2'b01) ? 2 : 4);
    mis = (a % sz) != 0;

    chk("mem_we",    s_mem_we,      32'(we && !mis && reset_n));
    chk("mem_addr",  bus.mem_addr,  32'(a));
    chk("mem_mode",  bus.mem_mode,  32'(md));
    chk("mem_wdata", bus.mem_wdata, wd);

    if (!reset_n) begin
      pend_own = 0;
      wcnt = 0;
    end else begin
      pend_own  = own;
      pend_load = !we;
      pend_err  = mis;
      pend_data = mread(a, sz);
      if (own != 0 && we && !mis) mwrite(a, sz, wd);
      if (!bus.dbg_req || own == 2) wcnt = 0;
      else if (wcnt < MAX_WAIT) wcnt = wcnt + 1;
    end
    cpu_hold = bus.cpu_req && own != 1;
  endtask

  task automatic cycle();
    @(negedge CLK);
    eval();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int first_gnt, second_gnt, stall_mask;
    bit any_gnt;
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    @(posedge CLK); #1;
    cycle();
    ram_clr = 1'b0;
    reset_n = 1'b1;
    cycle();

    // CPU alone: word store then word load
    any_gnt = 1'b0;
    set_cpu(1, 1, MODE_WORD, 8'h10, 32'hDEADBEEF);
    cycle(); any_gnt |= s_gnt;
    chk("t1_store_stall", s_stall, 0);
    set_cpu(1, 0, MODE_WORD, 8'h10, 32'h0);
    cycle(); any_gnt |= s_gnt;
    chk("t1_load_stall", s_stall, 0);
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle(); any_gnt |= s_gnt;
    chk("t1_rvalid", s_cpu_rvalid, 1);
    chk("t1_rdata", s_cpu_rdata, 32'hDEADBEEF);
    chk("t1_no_dbg_gnt", any_gnt, 0);

    // contention with CPU requesting every cycle
    first_gnt = -1; second_gnt = -1; stall_mask = 0;
    set_cpu(1, 0, MODE_BYTE, 8'h00, 32'h0);
    set_dbg(1, 0, MODE_WORD, 8'h10, 32'h0);
    for (int c = 0; c < 11; c++) begin
      cycle();
      if (c < 9 && s_stall) stall_mask |= (1 << c);
      if (s_gnt) begin
        if (first_gnt < 0) first_gnt = c;
        else if (second_gnt < 0) second_gnt = c;
      end
    end
    chk("t2_first_gnt", first_gnt, 4);
    chk("t2_second_gnt", second_gnt, 9);
    chk("t2_stall_mask", stall_mask, 32'h10);

    // misaligned accesses from both requesters
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    set_cpu(1, 0, MODE_HALF, 8'h21, 32'h0);
    cycle();
    chk("t3_cpu_mem_we", s_mem_we, 0);
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    set_dbg(1, 1, MODE_WORD, 8'h12, 32'hCAFEF00D);
    cycle();
    chk("t3_dbg_mem_we", s_mem_we, 0);
    chk("t3_cpu_err", s_cpu_err, 1);
    chk("t3_cpu_rvalid", s_cpu_rvalid, 0);
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    chk("t3_dbg_err", s_dbg_err, 1);
    chk("t3_dbg_rvalid", s_dbg_rvalid, 0);

    // back-to-back CPU byte load then DBG word load
    set_dbg(1, 1, MODE_WORD, 8'h04, 32'h11223344);
    cycle();
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    set_cpu(1, 1, MODE_BYTE, 8'h03, 32'h000000A5);
    cycle();
    set_cpu(1, 0, MODE_BYTE, 8'h03, 32'h0);
    cycle();
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    set_dbg(1, 0, MODE_WORD, 8'h04, 32'h0);
    cycle();
    chk("t4_cpu_rvalid", s_cpu_rvalid, 1);
    chk("t4_cpu_rdata", s_cpu_rdata, 32'h000000A5);
    chk("t4_dbg_rdata_idle", s_dbg_rdata, 0);
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    chk("t4_dbg_rvalid", s_dbg_rvalid, 1);
    chk("t4_dbg_rdata", s_dbg_rdata, 32'h11223344);
    chk("t4_cpu_rdata_idle", s_cpu_rdata, 0);

    // reset asserted while a CPU load is in flight
    set_cpu(1, 0, MODE_WORD, 8'h10, 32'h0);
    @(negedge CLK);
    eval();
    reset_n = 1'b0;
    pend_own = 0;
    wcnt = 0;
    #1;
    chk("t5_rst_cpu_rvalid", bus.cpu_rvalid, 0);
    set_cpu(1, 1, MODE_WORD, 8'h20, 32'h55AA55AA);
    #1;
    chk("t5_rst_mem_we", bus.mem_we, 0);
    @(posedge CLK); #1;
    cycle();
    cycle();
    reset_n = 1'b1;
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    chk("t5_post_rst_rvalid", s_cpu_rvalid, 0);
    set_cpu(1, 0, MODE_WORD, 8'h10, 32'h0);
    cycle();
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    chk("t5_post_rst_rdata", s_cpu_rdata, 32'hDEADBEEF);

    // DBG store with CPU idle
    set_dbg(1, 1, MODE_HALF, 8'h30, 32'h0000BEEF);
    cycle();
    chk("t6_dbg_gnt", s_gnt, 1);
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    chk("t6_dbg_rvalid", s_dbg_rvalid, 1);
    chk("t6_dbg_rdata", s_dbg_rdata, 0);

    // random traffic; a stalled CPU holds its request
    for (int i = 0; i < 400; i++) begin
      if (!cpu_hold) begin
        if ($urandom_range(0, 3) != 0)
          set_cpu(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 31)), $urandom);
        else
          set_cpu(0, 0, MODE_BYTE, 8'($urandom_range(0, 31)), $urandom);
      end
      set_dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    set_cpu(0, 0, MODE_BYTE, 8'h00, 32'h0);
    set_dbg(0, 0, MODE_BYTE, 8'h00, 32'h0);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
